// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the
// two-port data memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam logic P_CPU = 1'b0;
   localparam logic P_DBG = 1'b1;

   localparam int DMEM_DEPTH = 100;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } port_req_t;

   function automatic logic oor(
      input logic [31:0] a,
      input int          depth
   );
      return a >= 32'($unsigned(depth));
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker;
// on a tie the port not served last wins.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

   always_comb begin
      winner = P_CPU;
      unique case (req)
         2'b01:   winner = P_CPU;
         2'b10:   winner = P_DBG;
         2'b11:   winner = ~last;
         default: winner = P_CPU;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the
// processor (port 0) and the loader/debug port (port 1).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   state_t     state;
   state_t     nstate;
   logic       win;
   logic       last;
   logic       pick;
   logic [1:0] reqv;
   port_req_t  p0;
   port_req_t  p1;
   port_req_t  sel;
   logic       live;
   logic       bad;

   assign reqv = {req1, req0};
   assign p0   = '{we: we0, addr: addr0, wdata: wdata0};
   assign p1   = '{we: we1, addr: addr1, wdata: wdata1};
   assign sel  = (win == P_DBG) ? p1 : p0;
   assign bad  = oor(sel.addr, DEPTH);

   // gate on rst too so an abort drops mem_we at once
   assign live = (state == SERVE) && rst;

   rr_pick2 u_pick (
      .req    (reqv),
      .last   (last),
      .winner (pick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         win   <= P_CPU;
         last  <= P_DBG;
      end else begin
         state <= nstate;
         if (state == IDLE && |reqv)
            win <= pick;
         if (state == SERVE)
            last <= win;
      end
   end

   always_comb begin
      nstate = state;
      mem_a  = '0;
      mem_wd = '0;
      mem_we = 1'b0;
      ack0   = 1'b0;
      ack1   = 1'b0;
      err0   = 1'b0;
      err1   = 1'b0;
      rdata0 = '0;
      rdata1 = '0;
      unique case (state)
         IDLE:  if (|reqv) nstate = SERVE;
         SERVE: nstate = IDLE;
      endcase
      if (live) begin
         mem_a  = sel.addr;
         mem_wd = sel.wdata;
         mem_we = sel.we & ~bad;
         if (win == P_DBG) begin
            ack1   = 1'b1;
            err1   = bad;
            rdata1 = bad ? '0 : mem_rd;
         end else begin
            ack0   = 1'b1;
            err0   = bad;
            rdata0 = bad ? '0 : mem_rd;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed spec cases plus random
// traffic checked against a transaction-level model.
module tb_dmem_arbiter;

   localparam int DEPTH = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        r [2];
   logic        w [2];
   logic [31:0] a [2];
   logic [31:0] d [2];

   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        mem_we;

   logic [31:0] ram [DEPTH] = '{default: 32'h0};
   logic [31:0] ref_mem [DEPTH];

   int serving;
   int last_p;
   int vectors = 0;
   int miscompares = 0;
   bit rnd_on = 1'b0;
   bit acked [2];

   always #5 clk = ~clk;

   assign req0   = r[0];
   assign req1   = r[1];
   assign we0    = w[0];
   assign we1    = w[1];
   assign addr0  = a[0];
   assign addr1  = a[1];
   assign wdata0 = d[0];
   assign wdata1 = d[1];

   dmem_arbiter #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .req1   (req1),
      .we0    (we0),
      .we1    (we1),
      .addr0  (addr0),
      .addr1  (addr1),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .ack0   (ack0),
      .ack1   (ack1),
      .rdata0 (rdata0),
      .rdata1 (rdata1),
      .err0   (err0),
      .err1   (err1),
      .mem_a  (mem_a),
      .mem_wd (mem_wd),
      .mem_we (mem_we),
      .mem_rd (mem_rd)
   );

   assign mem_rd = (mem_a < 32'(DEPTH)) ? ram[mem_a[6:0]] : 32'h0;

   always @(posedge clk)
      if (mem_we && mem_a < 32'(DEPTH))
         ram[mem_a[6:0]] <= mem_wd;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int p;
      if (!rst) begin
         serving = -1;
         last_p  = 1;
         return;
      end
      if (serving >= 0) begin
         p = serving;
         if (w[p] && a[p] < 32'(DEPTH))
            ref_mem[a[p][6:0]] = d[p];
         last_p  = p;
         serving = -1;
      end else if (r[0] || r[1]) begin
         if (r[0] && r[1]) serving = 1 - last_p;
         else serving = r[0] ? 0 : 1;
      end
   endtask

   task automatic check_all();
      int          p;
      logic        bad;
      logic [31:0] ea, ewd;
      logic [31:0] erd [2];
      logic        ewe;
      logic        eack [2];
      logic        eerr [2];
      ea = 0; ewd = 0; ewe = 0;
      erd = '{0, 0}; eack = '{0, 0}; eerr = '{0, 0};
      if (rst && serving >= 0) begin
         p       = serving;
         bad     = a[p] >= 32'(DEPTH);
         ea      = a[p];
         ewd     = d[p];
         ewe     = w[p] && !bad;
         eack[p] = 1'b1;
         eerr[p] = bad;
         erd[p]  = bad ? 32'h0 : ref_mem[a[p][6:0]];
      end
      chk("flags", {27'b0, ack0, ack1, err0, err1, mem_we},
          {27'b0, eack[0], eack[1], eerr[0], eerr[1], ewe});
      chk("mem_a", mem_a, ea);
      chk("mem_wd", mem_wd, ewd);
      chk("rdata0", rdata0, erd[0]);
      chk("rdata1", rdata1, erd[1]);
      acked[0] = ack0;
      acked[1] = ack1;
   endtask

   task automatic new_txn(input int p);
      int k;
      k    = $urandom_range(0, 7);
      r[p] = 1'b1;
      w[p] = $urandom_range(0, 1) == 1;
      d[p] = $urandom;
      if (k == 0) a[p] = 32'(DEPTH) + $urandom_range(0, 3);
      else if (k == 1) a[p] = $urandom;
      else if (k < 6) a[p] = $urandom_range(0, 15);
      else a[p] = $urandom_range(0, DEPTH - 1);
   endtask

   task automatic stim();
      for (int p = 0; p < 2; p++) begin
         if (acked[p]) begin
            if ($urandom_range(0, 3) != 0) new_txn(p);
            else r[p] = 1'b0;
         end else if (r[p] && serving != p &&
                      $urandom_range(0, 9) == 0) begin
            r[p] = 1'b0;
         end else if (!r[p] && $urandom_range(0, 2) == 0) begin
            new_txn(p);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      if (rnd_on) stim();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_inputs();
      for (int p = 0; p < 2; p++) begin
         r[p] = 0; w[p] = 0; a[p] = 0; d[p] = 0;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      idle_inputs();
      serving = -1;
      last_p  = 1;
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int nack [2];
      int seq [$];
      int pos [$];
      int nbad;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
      apply_reset();

      // read of word 0 after reset
      r[0] = 1; w[0] = 0; a[0] = 0;
      cycle();
      chk("rd0_ack", {31'b0, ack0}, 1);
      chk("rd0_err", {31'b0, err0}, 0);
      chk("rd0_data", rdata0, 0);
      r[0] = 0;
      cycle();

      // write then read back
      r[0] = 1; w[0] = 1; a[0] = 5; d[0] = 32'hDEADBEEF;
      cycle();
      chk("wr_ack", {31'b0, ack0}, 1);
      chk("wr_we", {31'b0, mem_we}, 1);
      chk("wr_addr", mem_a, 5);
      r[0] = 0;
      cycle();
      r[0] = 1; w[0] = 0;
      cycle();
      chk("rb_data", rdata0, 32'hDEADBEEF);
      r[0] = 0;
      cycle();

      // tie after reset alternates 0,1,0,1
      apply_reset();
      r[0] = 1; a[0] = 1; r[1] = 1; a[1] = 2;
      nack = '{0, 0};
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (ack0) begin seq.push_back(0); pos.push_back(i); nack[0]++; end
         if (ack1) begin seq.push_back(1); pos.push_back(i); nack[1]++; end
      end
      chk("tie_n", seq.size(), 4);
      for (int k = 0; k < seq.size() && k < 4; k++) begin
         chk("tie_port", seq[k], k % 2);
         chk("tie_pos", pos[k], 2 * k);
      end
      chk("tie_cnt0", nack[0], 2);
      chk("tie_cnt1", nack[1], 2);
      idle_inputs();
      cycle();

      // out-of-range write from port 1
      r[1] = 1; w[1] = 1; a[1] = 100; d[1] = 32'h12345678;
      cycle();
      chk("oor_ack", {31'b0, ack1}, 1);
      chk("oor_err", {31'b0, err1}, 1);
      chk("oor_we", {31'b0, mem_we}, 0);
      chk("oor_rd", rdata1, 0);
      idle_inputs();
      cycle();

      // reset in the middle of a port-0 write
      r[0] = 1; w[0] = 1; a[0] = 7; d[0] = 32'hCAFEF00D;
      cycle();
      #2;
      rst = 1'b0;
      #1;
      chk("abort_we", {31'b0, mem_we}, 0);
      chk("abort_ack", {31'b0, ack0}, 0);
      serving = -1;
      last_p  = 1;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      chk("abort_mem", ram[7], 32'h0);
      cycle();

      // one-cycle pulse on port 1 during port-0 service
      r[0] = 1; w[0] = 0; a[0] = 3;
      cycle();
      r[0] = 0; r[1] = 1; a[1] = 9;
      cycle();
      r[1] = 0;
      nack[1] = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (ack1) nack[1]++;
      end
      chk("pulse_ack1", nack[1], 0);

      // random traffic
      acked = '{0, 0};
      rnd_on = 1'b1;
      repeat (3000) cycle();
      rnd_on = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      idle_inputs();
      @(negedge clk);
      check_all();
      cycle();
      cycle();

      nbad = 0;
      for (int i = 0; i < DEPTH; i++)
         if (ram[i] !== ref_mem[i]) nbad++;
      chk("ram", nbad, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
